// File: rtl/morse_encoder_az.sv
// Morse encoder for letters A..Z: one letter per START, optional repeat loop.
// Unit-timed marks and gaps, with abort and invalid-letter error pulse.
module morse_encoder_az #(
    parameter int CLK_HZ     = 50000000,
    parameter int UNIT_HZ    = 2,
    parameter int DASH_UNITS = 3,
    parameter int GAP_UNITS  = 1,
    parameter int LGAP_UNITS = 3
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       START,
    input  logic       ABORT,
    input  logic [4:0] LETTER,
    input  logic       REPEAT,
    output logic       LEDR,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR
);

    localparam int DIV  = CLK_HZ / UNIT_HZ;
    localparam int TW   = $clog2(DIV);
    localparam int UMAX = (DASH_UNITS > LGAP_UNITS) ? DASH_UNITS : LGAP_UNITS;
    localparam int UW   = $clog2(UMAX + 1);

    localparam logic [TW-1:0] T_LAST = TW'(DIV - 1);
    localparam logic [UW-1:0] DASH_L = UW'(DASH_UNITS - 1);
    localparam logic [UW-1:0] GAP_L  = UW'(GAP_UNITS - 1);
    localparam logic [UW-1:0] LGAP_L = UW'(LGAP_UNITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        MARK,
        SPACE,
        LGAP,
        FIN
    } state_t;

    // {length, pattern left-aligned so the first symbol sits in bit 3}
    function automatic logic [6:0] lut(input logic [4:0] l);
        case (l)
            5'd0:    lut = {3'd2, 4'b0100};
            5'd1:    lut = {3'd4, 4'b1000};
            5'd2:    lut = {3'd4, 4'b1010};
            5'd3:    lut = {3'd3, 4'b1000};
            5'd4:    lut = {3'd1, 4'b0000};
            5'd5:    lut = {3'd4, 4'b0010};
            5'd6:    lut = {3'd3, 4'b1100};
            5'd7:    lut = {3'd4, 4'b0000};
            5'd8:    lut = {3'd2, 4'b0000};
            5'd9:    lut = {3'd4, 4'b0111};
            5'd10:   lut = {3'd3, 4'b1010};
            5'd11:   lut = {3'd4, 4'b0100};
            5'd12:   lut = {3'd2, 4'b1100};
            5'd13:   lut = {3'd2, 4'b1000};
            5'd14:   lut = {3'd3, 4'b1110};
            5'd15:   lut = {3'd4, 4'b0110};
            5'd16:   lut = {3'd4, 4'b1101};
            5'd17:   lut = {3'd3, 4'b0100};
            5'd18:   lut = {3'd3, 4'b0000};
            5'd19:   lut = {3'd1, 4'b1000};
            5'd20:   lut = {3'd3, 4'b0010};
            5'd21:   lut = {3'd4, 4'b0001};
            5'd22:   lut = {3'd3, 4'b0110};
            5'd23:   lut = {3'd4, 4'b1001};
            5'd24:   lut = {3'd4, 4'b1011};
            5'd25:   lut = {3'd4, 4'b1100};
            default: lut = 7'd0;
        endcase
    endfunction

    state_t        state;
    logic [TW-1:0] tcnt;
    logic [UW-1:0] ucnt;
    logic [3:0]    pat_q;
    logic [2:0]    len_q;
    logic [3:0]    sr;
    logic [2:0]    rem;
    logic          rpt;

    logic [6:0]    entry;
    logic [UW-1:0] lim;
    logic          tick;
    logic          unit_end;

    always_comb begin
        entry = lut(LETTER);
        tick  = (tcnt == T_LAST);
        lim   = '0;
        case (state)
            MARK:    lim = sr[3] ? DASH_L : '0;
            SPACE:   lim = GAP_L;
            LGAP:    lim = LGAP_L;
            default: lim = '0;
        endcase
        unit_end = tick && (ucnt == lim);
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state <= IDLE;
            tcnt  <= '0;
            ucnt  <= '0;
            pat_q <= '0;
            len_q <= '0;
            sr    <= '0;
            rem   <= '0;
            rpt   <= 1'b0;
            LEDR  <= 1'b0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            ERR   <= 1'b0;
        end else begin
            DONE <= 1'b0;
            ERR  <= 1'b0;
            unique case (state)
                IDLE: begin
                    tcnt <= '0;
                    ucnt <= '0;
                    if (START) begin
                        if (LETTER < 5'd26) begin
                            pat_q <= entry[3:0];
                            len_q <= entry[6:4];
                            sr    <= entry[3:0];
                            rem   <= entry[6:4];
                            rpt   <= REPEAT;
                            state <= MARK;
                            LEDR  <= 1'b1;
                            BUSY  <= 1'b1;
                        end else begin
                            ERR <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                MARK, SPACE, LGAP: begin
                    if (ABORT) begin
                        state <= IDLE;
                        tcnt  <= '0;
                        ucnt  <= '0;
                        LEDR  <= 1'b0;
                        BUSY  <= 1'b0;
                    end else if (!tick) begin
                        tcnt <= tcnt + TW'(1);
                    end else if (!unit_end) begin
                        tcnt <= '0;
                        ucnt <= ucnt + UW'(1);
                    end else begin
                        tcnt <= '0;
                        ucnt <= '0;
                        if (state == MARK) begin
                            LEDR <= 1'b0;
                            if (rem > 3'd1) begin
                                state <= SPACE;
                                rem   <= rem - 3'd1;
                                sr    <= {sr[2:0], 1'b0};
                            end else if (rpt && REPEAT) begin
                                state <= LGAP;
                            end else begin
                                state <= FIN;
                                BUSY  <= 1'b0;
                                DONE  <= 1'b1;
                            end
                        end else if (state == SPACE) begin
                            state <= MARK;
                            LEDR  <= 1'b1;
                        end else begin
                            // the loop restarts the same latched letter
                            state <= MARK;
                            LEDR  <= 1'b1;
                            sr    <= pat_q;
                            rem   <= len_q;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_morse_encoder_az.sv
// Bench for morse_encoder_az: waveforms built from Morse strings and unit
// durations, compared cycle by cycle as {LEDR,BUSY,DONE,ERR}.
module tb_morse_encoder_az;

    localparam int U = 4;

    logic       CLOCK_50 = 1'b0;
    logic       RESET    = 1'b1;
    logic       START    = 1'b0;
    logic       ABORT    = 1'b0;
    logic [4:0] LETTER   = '0;
    logic       REPEAT   = 1'b0;
    logic       LEDR;
    logic       BUSY;
    logic       DONE;
    logic       ERR;

    int errors = 0;
    int checks = 0;

    logic [3:0] exp_q[$];

    string mtab[26] = '{
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
        ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
        "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."
    };

    morse_encoder_az #(
        .CLK_HZ(8),
        .UNIT_HZ(2)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .RESET(RESET),
        .START(START),
        .ABORT(ABORT),
        .LETTER(LETTER),
        .REPEAT(REPEAT),
        .LEDR(LEDR),
        .BUSY(BUSY),
        .DONE(DONE),
        .ERR(ERR)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        obs = {LEDR, BUSY, DONE, ERR};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Expected per-cycle outputs from the first busy cycle through DONE.
    task automatic build(input int l, input int reps);
        string s;
        s = mtab[l];
        exp_q.delete();
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < s.len(); i++) begin
                int n;
                n = (s[i] == "-") ? 3 * U : U;
                for (int c = 0; c < n; c++) exp_q.push_back(4'b1100);
                if (i < s.len() - 1)
                    for (int c = 0; c < U; c++) exp_q.push_back(4'b0100);
            end
            if (r < reps - 1)
                for (int c = 0; c < 3 * U; c++) exp_q.push_back(4'b0100);
        end
        exp_q.push_back(4'b0010);
    endtask

    task automatic send(input logic [4:0] l, input logic rep, input logic ab);
        LETTER = l;
        REPEAT = rep;
        START  = 1'b1;
        ABORT  = ab;
        step();
        START  = 1'b0;
        ABORT  = 1'b0;
    endtask

    // kill: 0 none, 1 abort, 2 reset, asserted after sample kill_at
    task automatic run(input string tag, input int limit, input bit noise,
                       input int drop_at, input int kill, input int kill_at);
        for (int k = 0; k < limit; k++) begin
            chk(tag, exp_q[k]);
            if (noise && k < exp_q.size() - 1) begin
                START  = 1'($urandom);
                LETTER = 5'($urandom);
            end else begin
                START = 1'b0;
            end
            if (k == drop_at) REPEAT = 1'b0;
            ABORT = (kill == 1 && k == kill_at);
            RESET = (kill == 2 && k == kill_at);
            step();
        end
        START = 1'b0;
        ABORT = 1'b0;
        RESET = 1'b0;
    endtask

    initial begin
        step();
        step();
        chk("reset", 4'b0000);
        RESET = 1'b0;
        step();
        chk("idle", 4'b0000);

        ABORT = 1'b1;
        step();
        ABORT = 1'b0;
        chk("abort_idle", 4'b0000);

        send(5'd4, 1'b0, 1'b0);
        build(4, 1);
        run("letter_E", exp_q.size(), 1'b0, -1, 0, 0);
        chk("E_after", 4'b0000);

        send(5'd0, 1'b0, 1'b0);
        build(0, 1);
        run("letter_A", exp_q.size(), 1'b0, -1, 0, 0);
        chk("A_after", 4'b0000);

        send(5'd19, 1'b1, 1'b0);
        build(19, 2);
        run("repeat_T", exp_q.size(), 1'b0, 3 * U + 3 * U + 4, 0, 0);
        chk("repeat_after", 4'b0000);

        send(5'd16, 1'b0, 1'b0);
        build(16, 1);
        run("abort_Q", 6 * U, 1'b0, -1, 1, 6 * U - 1);
        chk("abort_Q_idle", 4'b0000);
        for (int c = 0; c < 3 * U; c++) begin
            step();
            chk("abort_Q_nodone", 4'b0000);
        end
        send(5'd4, 1'b0, 1'b0);
        build(4, 1);
        run("after_abort_E", exp_q.size(), 1'b0, -1, 0, 0);

        LETTER = 5'd27;
        START  = 1'b1;
        step();
        START  = 1'b0;
        chk("err_27", 4'b0001);
        step();
        chk("err_27_clear", 4'b0000);

        send(5'd25, 1'b0, 1'b0);
        build(25, 1);
        run("reset_Z", 8 * U + 2, 1'b0, -1, 2, 8 * U + 1);
        chk("reset_Z_idle", 4'b0000);
        step();
        chk("reset_Z_idle2", 4'b0000);
        send(5'd4, 1'b0, 1'b0);
        build(4, 1);
        run("after_reset_E", exp_q.size(), 1'b0, -1, 0, 0);

        send(5'd4, 1'b0, 1'b1);
        build(4, 1);
        run("start_abort_E", exp_q.size(), 1'b0, -1, 0, 0);

        for (int t = 0; t < 10; t++) begin
            int l;
            l = int'($urandom_range(25, 0));
            send(5'(l), 1'b0, 1'b0);
            build(l, 1);
            run($sformatf("rand_%0d", l), exp_q.size(), 1'b1, -1, 0, 0);
            chk("rand_after", 4'b0000);
        end

        for (int t = 0; t < 4; t++) begin
            LETTER = 5'($urandom_range(31, 26));
            START  = 1'b1;
            step();
            START  = 1'b0;
            chk("err_rand", 4'b0001);
            step();
            chk("err_rand_clear", 4'b0000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
